// File: rtl/game_display_driver_pkg.sv
// rtl/game_display_driver_pkg.sv - shared game status codes and 7-segment glyph constants
// Package contents:
//   game_status_t    two-bit game status shared with the game controller
//   SEG_*            active-high glyphs, bit order {dp,g,f,e,d,c,b,a}
//   CODE_*           decoder input codes for the non-numeric glyphs
package game_display_driver_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } game_status_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_P     = 8'h73;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Decoder codes 0..9 are the decimal digits; letters and blank follow.
    localparam logic [3:0] CODE_C     = 4'd10;
    localparam logic [3:0] CODE_P     = 4'd11;
    localparam logic [3:0] CODE_DASH  = 4'd12;
    localparam logic [3:0] CODE_D     = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd14;

endpackage

// File: rtl/game_display_driver_seg_decoder.sv
// rtl/game_display_driver_seg_decoder.sv - 4-bit code to 7-segment glyph decoder
// Ports:
//   code   in  4  0..9 digits, 10 'C', 11 'P', 12 '-', 13 'd', 14/15 blank
//   glyph  out 8  active-high segments {dp,g,f,e,d,c,b,a}, dp always 0
module game_display_driver_seg_decoder
    import game_display_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'd0:       glyph = SEG_0;
            4'd1:       glyph = SEG_1;
            4'd2:       glyph = SEG_2;
            4'd3:       glyph = SEG_3;
            4'd4:       glyph = SEG_4;
            4'd5:       glyph = SEG_5;
            4'd6:       glyph = SEG_6;
            4'd7:       glyph = SEG_7;
            4'd8:       glyph = SEG_8;
            4'd9:       glyph = SEG_9;
            CODE_C:     glyph = SEG_C;
            CODE_P:     glyph = SEG_P;
            CODE_DASH:  glyph = SEG_DASH;
            CODE_D:     glyph = SEG_D;
            default:    glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_display_driver.sv
// rtl/game_display_driver.sv - 8-digit multiplexed 7-segment and flow-LED driver for the game
// Ports:
//   clk_d        in  1  system clock, rising edge
//   rst          in  1  asynchronous active-low reset
//   game_status  in  2  CHOSE_BOARD / GAMING / GAME_INITIAL / WINNED
//   board_num    in  5  selected board 0..31
//   step_number  in  6  moves taken 0..63
//   seg_an       out 8  one-hot digit select, bit 0 = rightmost
//   seg_out      out 8  segments {dp,g,f,e,d,c,b,a}
//   flow_led     out 8  running light while WINNED
module game_display_driver
    import game_display_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned FLOW_DIV  = 6250000
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic [1:0] game_status,
    input  logic [4:0] board_num,
    input  logic [5:0] step_number,
    output logic [7:0] seg_an,
    output logic [7:0] seg_out,
    output logic [7:0] flow_led
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int FLOW_W  = $clog2(FLOW_DIV);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic [FLOW_W-1:0]  flow_cnt;
    logic               prev_win;

    logic       is_win;
    logic       win_entry;
    logic       blink_wrap;
    logic       blink_on_next;
    logic       blank;
    logic [3:0] digit_code;
    logic [7:0] glyph;

    assign is_win     = (game_status == WINNED);
    assign win_entry  = is_win && !prev_win;
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // The display is gated by the blink phase being loaded on this edge, so
    // the dark half-period lines up exactly with the blink_on register.
    always_comb begin
        blink_on_next = 1'b1;
        if (is_win && !win_entry) begin
            blink_on_next = blink_wrap ? !blink_on : blink_on;
        end
        blank = is_win && !blink_on_next;
    end

    always_comb begin
        digit_code = CODE_BLANK;
        case (digit_idx)
            3'd7: begin
                case (game_status_t'(game_status))
                    CHOSE_BOARD:  digit_code = CODE_C;
                    GAMING:       digit_code = CODE_P;
                    GAME_INITIAL: digit_code = CODE_DASH;
                    WINNED:       digit_code = CODE_D;
                    default:      digit_code = CODE_BLANK;
                endcase
            end
            3'd5:    digit_code = 4'(board_num / 5'd10);
            3'd4:    digit_code = 4'(board_num % 5'd10);
            3'd1:    digit_code = 4'(step_number / 6'd10);
            3'd0:    digit_code = 4'(step_number % 6'd10);
            default: digit_code = CODE_BLANK;
        endcase
    end

    game_display_driver_seg_decoder u_seg_decoder (
        .code  (digit_code),
        .glyph (glyph)
    );

    always_ff @(posedge clk_d or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            flow_cnt  <= '0;
            prev_win  <= 1'b0;
            seg_an    <= '0;
            seg_out   <= '0;
            flow_led  <= '0;
        end else begin
            prev_win <= is_win;

            // Scanning never stops, even while blanked, so the position is
            // independent of status changes.
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            blink_on <= blink_on_next;
            if (!is_win || win_entry || blink_wrap) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (!is_win) begin
                flow_led <= '0;
                flow_cnt <= '0;
            end else if (win_entry) begin
                flow_led <= 8'h01;
                flow_cnt <= '0;
            end else if (flow_cnt == FLOW_W'(FLOW_DIV - 1)) begin
                flow_led <= {flow_led[6:0], flow_led[7]};
                flow_cnt <= '0;
            end else begin
                flow_cnt <= flow_cnt + 1'b1;
            end

            seg_an  <= blank ? 8'h00 : (8'h01 << digit_idx);
            seg_out <= blank ? 8'h00 : glyph;
        end
    end

endmodule

// File: doc/game_display_driver.md
Name: game_display_driver

Overview:
- Downstream display stage for the game top level.
- Consumes `game_status`, `step_number` and the selected board number, and drives an 8-digit multiplexed 7-segment display plus the 8-bit `flow_led` bank.
- Provides the status letter, the board number and the step count.
- In the WINNED state it also provides a digit blink and a running-light celebration.

Parameters:
- SCAN_DIV, 50000: clk_d cycles each digit stays selected (range ≥2).
- BLINK_DIV, 12500000: clk_d cycles per blink half-period in WINNED (range ≥2).
- FLOW_DIV, 6250000: clk_d cycles per `flow_led` shift in WINNED (range ≥2).

Ports:
- clk_d  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- game_status  in  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- board_num  in  5  selected board, 0..31.
- step_number  in  6  moves taken, 0..63.
- seg_an  out  8  digit select, one-hot, active-high; bit 0 = rightmost digit.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- flow_led  out  8  celebration running light.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; `scan_cnt`, `digit_idx`, `blink_cnt` and `flow_cnt` = 0; `blink_on` = 1.
- Scan:
  - `scan_cnt` counts 0..SCAN_DIV-1, then wraps.
  - On wrap, `digit_idx` increments mod 8 (7 → 0).
  - Every digit is scanned, including blank ones, to keep brightness uniform.
- Digit map:
  - d7: status letter — CHOSE_BOARD 'C' 0x39, GAMING 'P' 0x73, GAME_INITIAL '-' 0x40, WINNED 'd' 0x5E.
  - d6: blank 0x00.
  - d5: board_num/10; d4: board_num%10.
  - d3, d2: blank.
  - d1: step_number/10; d0: step_number%10.
  - Tens digits always show, including a leading 0.
- Glyphs: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. dp is always 0.
- Output timing:
  - `seg_an` and `seg_out` are registered; each is computed from the current `digit_idx` and current inputs.
  - Latency from an input change to `seg_out` is 1 cycle when that digit is selected.
  - First post-reset edge: `seg_an` = 0x01 with the d0 glyph.
- Blink (WINNED only):
  - On entry to WINNED (previous status ≠ 11): `blink_cnt` = 0 and `blink_on` = 1.
  - Thereafter `blink_on` toggles every BLINK_DIV cycles.
  - While `blink_on` = 0: `seg_an` = 0x00 and `seg_out` = 0x00; scanning continues underneath.
  - Outside WINNED: `blink_on` is forced to 1.
- Flow LED:
  - On entry to WINNED: `flow_led` = 0x01 and `flow_cnt` = 0.
  - Every FLOW_DIV cycles, rotate left; 0x80 → 0x01.
  - In any other state: `flow_led` = 0 on the next edge.
- Status changes mid-scan: scan position is not disturbed; only glyphs, blink and flow follow the new status.
- WINNED → WINNED with no exit is not an entry; counters continue.
- Out-of-range inputs are impossible by width (max 31 / 63); the /10 and %10 logic needs no saturation.
- Reset asserted mid-operation: immediate return to reset values, regardless of the clock.

Decomposition:
- Shared package holds:
  - game status codes CHOSE_BOARD/GAMING/GAME_INITIAL/WINNED (also consumed by fsm/playController);
  - 7-segment glyph constants SEG_0..SEG_9, SEG_C, SEG_P, SEG_DASH, SEG_D, SEG_BLANK.
- One sub-module: seg_decoder, a combinational 4-bit code → 8-bit glyph decoder, with codes 10..14 used for the letters and blank.
- Binary-to-decimal split (/10, %10 on ≤6 bits) is inline combinational logic.

Test Plan (SCAN_DIV=4, BLINK_DIV=16, FLOW_DIV=8):
- Reset and scan:
  - Hold rst=0, then release with status=00, board=7, step=0.
  - `seg_an` = 0x01/seg 3F for 4 cycles, then 0x02/3F, then 0x04/00, then 0x08/00, 0x10/07, 0x20/3F, 0x40/00, 0x80/39.
  - Wraps back to 0x01 after 32 cycles.
- Decimal split:
  - status=01, board=31, step=63.
  - d5=4F, d4=06, d1=7D, d0=4F, d7=73.
  - Changing step to 10 while d0 is selected gives d0=3F on the next edge.
- Win entry:
  - status goes 01→11.
  - `flow_led` = 0x01 the next cycle, then 0x02 after 8 cycles; 0x80 rotates to 0x01 after 64 cycles.
  - `seg_an` = 0x00 for cycles 16..31 after entry, then resumes.
- Win exit:
  - Mid-blink-off, status goes 11→00.
  - Next edge: `flow_led` = 0x00, `seg_an` nonzero, d7 = 39.
- Re-entry:
  - 11→01→11.
  - `flow_led` restarts at 0x01 and the blink restarts in the on phase.
- Async reset:
  - Assert rst=0 between clock edges during WINNED.
  - All outputs go to 0 immediately, without waiting for clk_d.
